// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic-light controller and its sensor stage.
// Contents:
//   db_state_t - lane debounce states (IDLE / RISE / OCCUPIED / FALL)
//   LIGHT_*    - light encodings {Red, Yellow, Green} used by the controller
package traffic_pkg;

  typedef enum logic [1:0] {
    DB_IDLE     = 2'd0,
    DB_RISE     = 2'd1,
    DB_OCCUPIED = 2'd2,
    DB_FALL     = 2'd3
  } db_state_t;

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_GREEN  = 2'd2;

endpackage

// File: rtl/lane_debounce.sv
// lane_debounce
// Synchronises one raw loop sensor and debounces it; emits a one-cycle
// vehicle event each time the lane goes from empty to occupied.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset
//   car      in  raw asynchronous sensor, 1 = vehicle present
//   vehicle  out one-cycle event, decoded from registered state only
// Parameter: DEBOUNCE_CYCLES (>=1) consecutive samples to accept a change.
module lane_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic car,
  output logic vehicle
);

  localparam int STB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(DEBOUNCE_CYCLES - 1);
  // With a one-sample debounce the RISE/FALL states resolve immediately.
  localparam logic SINGLE = (DEBOUNCE_CYCLES == 1) ? 1'b1 : 1'b0;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("lane_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             sync1_r;
  logic             sync2_r;
  db_state_t        state_r;
  logic [STB_W-1:0] stable_r;

  // Two-flop synchroniser for the asynchronous sensor.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= car;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM; stable_r counts consecutive samples at the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= DB_IDLE;
      stable_r <= '0;
    end else begin
      case (state_r)
        DB_IDLE: begin
          if (sync2_r) begin
            if (SINGLE) begin
              state_r <= DB_OCCUPIED;
            end else begin
              state_r  <= DB_RISE;
              stable_r <= STB_W'(1);
            end
          end
        end
        DB_RISE: begin
          if (!sync2_r) begin
            state_r <= DB_IDLE;
          end else if (stable_r == STB_LAST) begin
            state_r <= DB_OCCUPIED;
          end else begin
            stable_r <= stable_r + STB_W'(1);
          end
        end
        DB_OCCUPIED: begin
          if (!sync2_r) begin
            if (SINGLE) begin
              state_r <= DB_IDLE;
            end else begin
              state_r  <= DB_FALL;
              stable_r <= STB_W'(1);
            end
          end
        end
        DB_FALL: begin
          if (sync2_r) begin
            state_r <= DB_OCCUPIED;
          end else if (stable_r == STB_LAST) begin
            state_r <= DB_IDLE;
          end else begin
            stable_r <= stable_r + STB_W'(1);
          end
        end
        default: begin
          state_r  <= DB_IDLE;
          stable_r <= '0;
        end
      endcase
    end
  end

  // Event fires in the cycle whose closing edge moves the FSM into OCCUPIED,
  // so the accumulator counts it on that same edge.
  always_comb begin
    vehicle = 1'b0;
    if (sync2_r && (state_r == DB_RISE) && (stable_r == STB_LAST)) begin
      vehicle = 1'b1;
    end else if (sync2_r && SINGLE && (state_r == DB_IDLE)) begin
      vehicle = 1'b1;
    end else begin
      vehicle = 1'b0;
    end
  end

endmodule

// File: rtl/traffic_density_detector.sv
// traffic_density_detector
// Counts debounced vehicles per lane over a fixed window and raises the
// high_ns / high_ew demand flags for the traffic-light controller.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   ns_car, ew_car       raw asynchronous loop sensors
//   high_ns, high_ew     demand flags (registered)
//   ns_count, ew_count   vehicle counts of the last completed window
//   window_tick          high during the last cycle of each window
// Build option: DENSITY_HYST_EN selects hysteresis (HIGH_TH set / LOW_TH
// clear); without it the flag is simply (count >= HIGH_TH) each window.
module traffic_density_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 1000,
  parameter int CNT_W           = 8,
  parameter int HIGH_TH         = 20,
  parameter int LOW_TH          = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ns_car,
  input  logic             ew_car,
  output logic             high_ns,
  output logic             high_ew,
  output logic [CNT_W-1:0] ns_count,
  output logic [CNT_W-1:0] ew_count,
  output logic             window_tick
);

  localparam int WIN_W = (WINDOW_CYCLES <= 2) ? 1 : $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_PRE  = WIN_W'(WINDOW_CYCLES - 2);
  localparam logic [CNT_W-1:0] HIGH_V   = CNT_W'(HIGH_TH);

  if (WINDOW_CYCLES < 2) begin : g_bad_window
    $error("traffic_density_detector: WINDOW_CYCLES must be >= 2");
  end
  if ((LOW_TH >= HIGH_TH) || (HIGH_TH > ((1 << CNT_W) - 1))) begin : g_bad_th
    $error("traffic_density_detector: need LOW_TH < HIGH_TH <= 2^CNT_W-1");
  end

  logic             ns_event_s;
  logic             ew_event_s;
  logic [WIN_W-1:0] win_r;
  logic [CNT_W-1:0] ns_acc_r;
  logic [CNT_W-1:0] ew_acc_r;
  logic [CNT_W-1:0] ns_final_s;
  logic [CNT_W-1:0] ew_final_s;
  logic             ns_flag_s;
  logic             ew_flag_s;

  lane_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ns_debounce (
    .clk     (clk),
    .reset   (reset),
    .car     (ns_car),
    .vehicle (ns_event_s)
  );

  lane_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ew_debounce (
    .clk     (clk),
    .reset   (reset),
    .car     (ew_car),
    .vehicle (ew_event_s)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic inc);
    if (inc && (a != {CNT_W{1'b1}})) begin
      sat_inc = a + CNT_W'(1);
    end else begin
      sat_inc = a;
    end
  endfunction

  // Window counter; the tick is registered one cycle ahead so that it is
  // high exactly while the counter sits on its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_r       <= '0;
      window_tick <= 1'b0;
    end else begin
      if (win_r == WIN_LAST) begin
        win_r <= '0;
      end else begin
        win_r <= win_r + WIN_W'(1);
      end
      window_tick <= (win_r == WIN_PRE);
    end
  end

  // Closing totals include an event arriving on the tick cycle itself.
  always_comb begin
    ns_final_s = sat_inc(ns_acc_r, ns_event_s);
    ew_final_s = sat_inc(ew_acc_r, ew_event_s);
  end

  // Next flag values from the closing totals.
  always_comb begin
    ns_flag_s = high_ns;
    ew_flag_s = high_ew;
`ifdef DENSITY_HYST_EN
    if (ns_final_s >= HIGH_V) begin
      ns_flag_s = 1'b1;
    end else if (ns_final_s <= CNT_W'(LOW_TH)) begin
      ns_flag_s = 1'b0;
    end else begin
      ns_flag_s = high_ns;
    end
    if (ew_final_s >= HIGH_V) begin
      ew_flag_s = 1'b1;
    end else if (ew_final_s <= CNT_W'(LOW_TH)) begin
      ew_flag_s = 1'b0;
    end else begin
      ew_flag_s = high_ew;
    end
`else
    ns_flag_s = (ns_final_s >= HIGH_V);
    ew_flag_s = (ew_final_s >= HIGH_V);
`endif
  end

  // Accumulators, published counts and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ns_acc_r <= '0;
      ew_acc_r <= '0;
      ns_count <= '0;
      ew_count <= '0;
      high_ns  <= 1'b0;
      high_ew  <= 1'b0;
    end else if (window_tick) begin
      ns_acc_r <= '0;
      ew_acc_r <= '0;
      ns_count <= ns_final_s;
      ew_count <= ew_final_s;
      high_ns  <= ns_flag_s;
      high_ew  <= ew_flag_s;
    end else begin
      ns_acc_r <= ns_final_s;
      ew_acc_r <= ew_final_s;
    end
  end

endmodule
